// File: rtl/bh1750_pkg.sv
// Shared BH1750 definitions: FSM states, opcodes and read-byte selection.
package bh1750_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } state_e;

  localparam logic [7:0] OP_PWR_DOWN   = 8'h00;
  localparam logic [7:0] OP_PWR_ON     = 8'h01;
  localparam logic [7:0] OP_RESET      = 8'h07;
  localparam logic [7:0] OP_MODE_CHR   = 8'h10;
  localparam logic [7:0] OP_MODE_CHR2  = 8'h11;
  localparam logic [7:0] OP_MODE_CLR   = 8'h13;
  localparam logic [7:0] OP_MODE_OTH   = 8'h20;
  localparam logic [7:0] OP_MODE_OTH2  = 8'h21;
  localparam logic [7:0] OP_MODE_OTL   = 8'h23;
  localparam logic [7:0] DEFAULT_MODE  = OP_MODE_CHR;

  function automatic logic is_mode_op(input logic [7:0] op);
    case (op)
      OP_MODE_CHR, OP_MODE_CHR2, OP_MODE_CLR,
      OP_MODE_OTH, OP_MODE_OTH2, OP_MODE_OTL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Bytes past the 16-bit measurement read as all ones; the index never wraps.
  function automatic logic [7:0] read_byte_sel(input logic [15:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    return data[15:8];
      2'd1:    return data[7:0];
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C pin synchronizer with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl;

  // Synchronize raw pins and keep a one-cycle-old copy of the synchronized levels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync_q[SYNC_STAGES-1];
  assign sda      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_prev_q;
  assign scl_fall = ~scl & scl_prev_q;
  // SDA edges only count as conditions when SCL was high on both samples.
  assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/bh1750_i2c_target.sv
// BH1750 light-sensor emulation as an I2C target: opcode decode on write, 16-bit result on read.
module bh1750_i2c_target
  import bh1750_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h23,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        sda_dir,
  input  logic [15:0] meas_data,
  output logic        powered,
  output logic [7:0]  mode,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        meas_reset,
  output logic        busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk     (clk),
    .reset   (reset),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start_det),
    .stop    (stop_det)
  );

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_done_q, byte_done_d;  // all bits of the current byte handled
  logic        rw_q, rw_d;
  logic        nack_q, nack_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic        sda_dir_q, sda_dir_d;
  logic        powered_q, powered_d;
  logic [7:0]  mode_q, mode_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        meas_reset_q, meas_reset_d;
  logic        busy_q, busy_d;

  logic [1:0]  next_idx;
  logic [7:0]  cur_byte, next_byte;

  assign next_idx  = (byte_idx_q == 2'd3) ? 2'd3 : byte_idx_q + 2'd1;
  assign cur_byte  = read_byte_sel(shadow_q, byte_idx_q);
  assign next_byte = read_byte_sel(shadow_q, next_idx);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= 3'd7;
      byte_done_q  <= 1'b0;
      rw_q         <= 1'b0;
      nack_q       <= 1'b0;
      byte_idx_q   <= '0;
      shadow_q     <= '0;
      sda_dir_q    <= 1'b0;
      powered_q    <= 1'b0;
      mode_q       <= DEFAULT_MODE;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
      meas_reset_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_done_q  <= byte_done_d;
      rw_q         <= rw_d;
      nack_q       <= nack_d;
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      sda_dir_q    <= sda_dir_d;
      powered_q    <= powered_d;
      mode_q       <= mode_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      meas_reset_q <= meas_reset_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state SCL edge handling.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_done_d  = byte_done_q;
    rw_d         = rw_q;
    nack_d       = nack_q;
    byte_idx_d   = byte_idx_q;
    shadow_d     = shadow_q;
    sda_dir_d    = sda_dir_q;
    powered_d    = powered_q;
    mode_d       = mode_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    meas_reset_d = 1'b0;
    busy_d       = busy_q;

    if (start_det) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd7;
      byte_done_d = 1'b0;
      sda_dir_d   = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      sda_dir_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;

        StAddr, StWrByte: begin
          if (scl_rise && !byte_done_q) begin
            shift_d = {shift_q[6:0], sda};
            if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
            else                   bit_cnt_d   = bit_cnt_q - 3'd1;
          end else if (scl_fall && byte_done_q) begin
            if (state_q == StAddr) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d   = StAddrAck;
                sda_dir_d = 1'b1;
                busy_d    = 1'b1;
                rw_d      = shift_q[0];
              end else begin
                state_d = StWaitStop;
              end
            end else begin
              state_d     = StWrAck;
              sda_dir_d   = 1'b1;
              cmd_valid_d = 1'b1;
              cmd_byte_d  = shift_q;
              if (shift_q == OP_PWR_DOWN)      powered_d    = 1'b0;
              else if (shift_q == OP_PWR_ON)   powered_d    = 1'b1;
              else if (shift_q == OP_RESET)    meas_reset_d = powered_q;
              else if (is_mode_op(shift_q))    mode_d       = shift_q;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d   = 3'd7;
            byte_done_d = 1'b0;
            if (!rw_q) begin
              state_d   = StWrByte;
              sda_dir_d = 1'b0;
            end else begin
              // Freeze the measurement for the whole read so bytes never tear.
              shadow_d   = meas_data;
              byte_idx_d = 2'd0;
              state_d    = StRdByte;
              sda_dir_d  = ~meas_data[15];
              bit_cnt_d  = 3'd6;
            end
          end
        end

        StWrAck: begin
          if (scl_fall) begin
            state_d     = StWrByte;
            sda_dir_d   = 1'b0;
            bit_cnt_d   = 3'd7;
            byte_done_d = 1'b0;
          end
        end

        StRdByte: begin
          if (scl_fall) begin
            if (byte_done_q) begin
              state_d   = StRdAck;
              sda_dir_d = 1'b0;
            end else begin
              sda_dir_d = ~cur_byte[bit_cnt_q];
              if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
              else                   bit_cnt_d   = bit_cnt_q - 3'd1;
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            nack_d = sda;
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d = StWaitStop;
            end else begin
              byte_idx_d  = next_idx;
              state_d     = StRdByte;
              sda_dir_d   = ~next_byte[7];
              bit_cnt_d   = 3'd6;
              byte_done_d = 1'b0;
            end
          end
        end

        StWaitStop: ;

        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_out    = 1'b0;
  assign sda_dir    = sda_dir_q;
  assign powered    = powered_q;
  assign mode       = mode_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign meas_reset = meas_reset_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Bench for bh1750_i2c_target: bit-banged I2C master on an open-drain bus.
module tb_bh1750_i2c_target;

  localparam int         Q   = 5;      // clk cycles per quarter SCL period
  localparam logic [6:0] DEV = 7'h23;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] meas_data = '0;
  logic        sda_out, sda_dir, powered, cmd_valid, meas_reset, busy;
  logic [7:0]  mode, cmd_byte;
  logic        sda_line;

  assign sda_line = sda_m & ~(sda_dir & ~sda_out);

  bh1750_i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_out   (sda_out),
    .sda_dir   (sda_dir),
    .meas_data (meas_data),
    .powered   (powered),
    .mode      (mode),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .meas_reset(meas_reset),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cmd_cnt = 0, mrst_cnt = 0, hi_viol = 0;
  logic scl_d1 = 1'b1, dir_d1 = 1'b0;

  // Count output pulses and any SDA drive change while SCL stays high.
  always @(negedge clk) begin
    if (cmd_valid) cmd_cnt++;
    if (meas_reset) mrst_cnt++;
    if (reset && scl_d1 && scl_m && (sda_dir != dir_d1)) hi_viol++;
    scl_d1 = scl_m;
    dir_d1 = sda_dir;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  // ack_n = 0 means the target acknowledged.
  task automatic put_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack_n);
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  typedef struct {
    logic            rd;
    logic [6:0]      addr;
    int              n;
    logic [2:0][7:0] wd;
    logic [15:0]     meas;
    logic            exp_ack;
    logic            exp_pw;
    logic [7:0]      exp_mode;
    logic [2:0][7:0] exp_rd;
    int              exp_cmds;
    int              exp_mrst;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic [6:0] addr, input int n,
                              input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input logic [15:0] meas, input logic ack, input logic pw,
                              input logic [7:0] md, input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input int cmds, input int mrst);
    vec_t v;
    v.rd = rd; v.addr = addr; v.n = n; v.meas = meas;
    v.wd[0] = w0; v.wd[1] = w1; v.wd[2] = w2;
    v.exp_ack = ack; v.exp_pw = pw; v.exp_mode = md;
    v.exp_rd[0] = r0; v.exp_rd[1] = r1; v.exp_rd[2] = r2;
    v.exp_cmds = cmds; v.exp_mrst = mrst;
    return v;
  endfunction

  task automatic apply_check(input vec_t v, input string tag);
    logic       ack_n;
    logic [7:0] b;
    int         c0, m0;
    c0 = cmd_cnt;
    m0 = mrst_cnt;
    meas_data = v.meas;
    bus_start();
    put_byte({v.addr, v.rd}, ack_n);
    chk($sformatf("%s addr_ack", tag), {31'd0, ~ack_n}, {31'd0, v.exp_ack});
    if (v.exp_ack) begin
      for (int i = 0; i < v.n; i++) begin
        if (v.rd) begin
          get_byte(i == v.n - 1, b);
          chk($sformatf("%s rd_byte%0d", tag, i), {24'd0, b}, {24'd0, v.exp_rd[i]});
        end else begin
          put_byte(v.wd[i], ack_n);
          chk($sformatf("%s wr_ack%0d", tag, i), {31'd0, ack_n}, 32'd0);
        end
      end
    end
    chk($sformatf("%s busy_before_stop", tag), {31'd0, busy}, {31'd0, v.exp_ack});
    bus_stop();
    chk($sformatf("%s busy_after_stop", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s powered", tag), {31'd0, powered}, {31'd0, v.exp_pw});
    chk($sformatf("%s mode", tag), {24'd0, mode}, {24'd0, v.exp_mode});
    chk($sformatf("%s cmd_pulses", tag), cmd_cnt - c0, v.exp_cmds);
    chk($sformatf("%s meas_reset_pulses", tag), mrst_cnt - m0, v.exp_mrst);
    if (!v.rd && v.exp_ack)
      chk($sformatf("%s cmd_byte", tag), {24'd0, cmd_byte}, {24'd0, v.wd[v.n-1]});
  endtask

  vec_t vecs[12];

  initial begin
    logic       ack_n;
    logic [7:0] b0, b1, b2;
    int         c0, m0;
    logic       m_pw;
    logic [7:0] m_mode;
    logic [7:0] pool[9];
    vec_t       v;

    vecs[0]  = mk(0, DEV,   1, 8'h01, 8'h00, 8'h00, 16'h0, 1, 1, 8'h10, 0, 0, 0, 1, 0);
    vecs[1]  = mk(0, DEV,   1, 8'h10, 8'h00, 8'h00, 16'h0, 1, 1, 8'h10, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, DEV,   2, 8'h23, 8'h00, 8'h00, 16'h0, 1, 0, 8'h23, 0, 0, 0, 2, 0);
    vecs[3]  = mk(0, 7'h5C, 1, 8'h01, 8'h00, 8'h00, 16'h0, 0, 0, 8'h23, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, DEV,   2, 8'h55, 8'h11, 8'h00, 16'h0, 1, 0, 8'h11, 0, 0, 0, 2, 0);
    vecs[5]  = mk(1, DEV,   2, 8'h00, 8'h00, 8'h00, 16'hDEAD, 1, 0, 8'h11,
                  8'hDE, 8'hAD, 0, 0, 0);
    vecs[6]  = mk(0, DEV,   2, 8'h01, 8'h07, 8'h00, 16'h0, 1, 1, 8'h11, 0, 0, 0, 2, 1);
    vecs[7]  = mk(1, DEV,   3, 8'h00, 8'h00, 8'h00, 16'h1234, 1, 1, 8'h11,
                  8'h12, 8'h34, 8'hFF, 0, 0);
    vecs[8]  = mk(0, DEV,   3, 8'h20, 8'h07, 8'h00, 16'h0, 1, 0, 8'h20, 0, 0, 0, 3, 1);
    vecs[9]  = mk(0, DEV,   2, 8'h07, 8'h13, 8'h00, 16'h0, 1, 0, 8'h13, 0, 0, 0, 2, 0);
    vecs[10] = mk(1, 7'h5C, 1, 8'h00, 8'h00, 8'h00, 16'hBEEF, 0, 0, 8'h13, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, DEV,   1, 8'hFF, 8'h00, 8'h00, 16'h0, 1, 0, 8'h13, 0, 0, 0, 1, 0);

    // Reset state.
    tick(4);
    chk("rst sda_dir", {31'd0, sda_dir}, 32'd0);
    chk("rst sda_out", {31'd0, sda_out}, 32'd0);
    chk("rst powered", {31'd0, powered}, 32'd0);
    chk("rst mode", {24'd0, mode}, 32'h10);
    chk("rst cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst cmd_byte", {24'd0, cmd_byte}, 32'd0);
    chk("rst meas_reset", {31'd0, meas_reset}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick(10);

    foreach (vecs[i]) apply_check(vecs[i], $sformatf("vec%0d", i));

    // Shadow register: measurement changes between bytes, then bits after NACK are ignored.
    meas_data = 16'hDEAD;
    bus_start();
    put_byte({DEV, 1'b1}, ack_n);
    chk("shadow addr_ack", {31'd0, ack_n}, 32'd0);
    get_byte(1'b0, b0);
    meas_data = 16'h1234;
    get_byte(1'b1, b1);
    chk("shadow byte0", {24'd0, b0}, 32'hDE);
    chk("shadow byte1", {24'd0, b1}, 32'hAD);
    put_byte({DEV, 1'b0}, ack_n);
    chk("wait_stop ignores byte", {31'd0, ack_n}, 32'd1);
    chk("wait_stop busy", {31'd0, busy}, 32'd1);
    bus_stop();
    chk("wait_stop busy after stop", {31'd0, busy}, 32'd0);

    // Repeated START inside a write byte, then a three-byte read.
    c0 = cmd_cnt;
    meas_data = 16'hDEAD;
    bus_start();
    put_byte({DEV, 1'b0}, ack_n);
    chk("rs write addr_ack", {31'd0, ack_n}, 32'd0);
    put_bit(1'b0); put_bit(1'b0); put_bit(1'b0);
    bus_start();
    put_byte({DEV, 1'b1}, ack_n);
    chk("rs read addr_ack", {31'd0, ack_n}, 32'd0);
    get_byte(1'b0, b0);
    get_byte(1'b0, b1);
    get_byte(1'b1, b2);
    bus_stop();
    chk("rs byte0", {24'd0, b0}, 32'hDE);
    chk("rs byte1", {24'd0, b1}, 32'hAD);
    chk("rs byte2", {24'd0, b2}, 32'hFF);
    chk("rs partial byte no cmd", cmd_cnt - c0, 32'd0);

    // Measurement reset opcode while unpowered.
    m0 = mrst_cnt;
    bus_start();
    put_byte({DEV, 1'b0}, ack_n);
    put_byte(8'h07, ack_n);
    chk("op07 unpowered ack", {31'd0, ack_n}, 32'd0);
    bus_stop();
    chk("op07 unpowered no pulse", mrst_cnt - m0, 32'd0);
    chk("op07 cmd_byte", {24'd0, cmd_byte}, 32'h07);

    // Reset in the middle of a read while the target drives SDA low.
    bus_start();
    put_byte({DEV, 1'b0}, ack_n);
    put_byte(8'h01, ack_n);
    bus_stop();
    chk("pre-reset powered", {31'd0, powered}, 32'd1);
    meas_data = 16'h0000;
    bus_start();
    put_byte({DEV, 1'b1}, ack_n);
    tick(2);
    chk("mid-read sda_dir driving", {31'd0, sda_dir}, 32'd1);
    reset = 1'b0;
    tick(1);
    chk("mid-read reset sda_dir", {31'd0, sda_dir}, 32'd0);
    tick(3);
    chk("mid-read reset powered", {31'd0, powered}, 32'd0);
    chk("mid-read reset mode", {24'd0, mode}, 32'h10);
    chk("mid-read reset busy", {31'd0, busy}, 32'd0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    reset = 1'b1;
    tick(10);

    // Randomized transactions against a rule-level model.
    pool[0] = 8'h00; pool[1] = 8'h01; pool[2] = 8'h07; pool[3] = 8'h10; pool[4] = 8'h11;
    pool[5] = 8'h13; pool[6] = 8'h20; pool[7] = 8'h21; pool[8] = 8'h23;
    m_pw = 1'b0;
    m_mode = 8'h10;
    for (int t = 0; t < 20; t++) begin
      v.rd = ($urandom_range(0, 2) == 0);
      v.addr = DEV;
      if ($urandom_range(0, 4) == 0) begin
        v.addr = 7'($urandom);
        if (v.addr == DEV) v.addr = 7'h5C;
      end
      v.n = $urandom_range(1, 3);
      v.meas = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
        v.wd[i] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 8)];
        v.exp_rd[i] = (i == 0) ? v.meas[15:8] : (i == 1) ? v.meas[7:0] : 8'hFF;
      end
      v.exp_ack = (v.addr == DEV);
      v.exp_cmds = 0;
      v.exp_mrst = 0;
      if (v.exp_ack && !v.rd) begin
        for (int i = 0; i < v.n; i++) begin
          v.exp_cmds++;
          case (v.wd[i])
            8'h00: m_pw = 1'b0;
            8'h01: m_pw = 1'b1;
            8'h07: if (m_pw) v.exp_mrst++;
            8'h10, 8'h11, 8'h13, 8'h20, 8'h21, 8'h23: m_mode = v.wd[i];
            default: ;
          endcase
        end
      end
      v.exp_pw = m_pw;
      v.exp_mode = m_mode;
      apply_check(v, $sformatf("rand%0d", t));
    end

    chk("sda_dir stable while SCL high", hi_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
